// File: rtl/lab1_imul_req_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lab1_imul_req_queue_if                                            |
// | Brief   : val/rdy message channel carrying one {a,b} operand pair.          |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface lab1_imul_req_queue_if #(
   parameter int NBITS = 32
);
   logic               val;
   logic               rdy;
   logic [2*NBITS-1:0] msg;

   modport master (output val, output msg, input rdy);
   modport slave  (input val, input msg, output rdy);
endinterface
`default_nettype wire

// File: rtl/lab1_imul_req_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lab1_imul_req_queue                                               |
// | Brief   : Operand FIFO in front of the iterative multiplier. Defining       |
// |           LAB1_IMUL_REQ_QUEUE_SWAP_EN stores the smaller operand in b.      |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module lab1_imul_req_queue #(
   parameter int NBITS       = 32,
   parameter int NUM_ENTRIES = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   lab1_imul_req_queue_if.slave          req,
   lab1_imul_req_queue_if.master         out,
   output logic [$clog2(NUM_ENTRIES):0]  count
`ifdef LAB1_IMUL_REQ_QUEUE_SWAP_EN
   ,
   output logic [31:0]                   swap_cnt
`endif
);

   localparam int c_PTR_W = $clog2(NUM_ENTRIES);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(NUM_ENTRIES);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } occ_state_t;

   logic [2*NBITS-1:0] r_mem [NUM_ENTRIES];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic [c_CNT_W-1:0] w_count_nxt;
   logic               r_live;
   occ_state_t         w_state;
   logic               w_enq;
   logic               w_deq;
   logic [2*NBITS-1:0] w_wr_data;

   // r_live holds req_rdy low until the first edge after reset release.
   assign req.rdy   = r_live && (r_count != c_FULL);
   assign out.val   = (r_count != '0);
   assign out.msg   = r_mem[r_rd_ptr];
   assign count     = r_count;
   assign w_enq     = req.val && req.rdy;
   assign w_deq     = out.val && out.rdy;

`ifdef LAB1_IMUL_REQ_QUEUE_SWAP_EN
   logic [NBITS-1:0] w_a;
   logic [NBITS-1:0] w_b;
   logic             w_swap;
   logic [31:0]      r_swap_cnt;

   assign w_a       = req.msg[2*NBITS-1:NBITS];
   assign w_b       = req.msg[NBITS-1:0];
   assign w_swap    = (w_b > w_a);
   assign w_wr_data = w_swap ? {w_b, w_a} : req.msg;
   assign swap_cnt  = r_swap_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_swap_cnt <= 32'd0;
      end else if (w_enq && w_swap) begin
         r_swap_cnt <= r_swap_cnt + 32'd1;
      end
   end
`else
   assign w_wr_data = req.msg;
`endif

   always_comb begin
      w_state = ST_PARTIAL;
      if (r_count == '0) begin
         w_state = ST_EMPTY;
      end else if (r_count == c_FULL) begin
         w_state = ST_FULL;
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      case (w_state)
         ST_EMPTY: begin
            if (w_enq) w_count_nxt = c_CNT_W'(1);
         end
         ST_PARTIAL: begin
            if (w_enq && !w_deq) begin
               w_count_nxt = r_count + c_CNT_W'(1);
            end else if (w_deq && !w_enq) begin
               w_count_nxt = r_count - c_CNT_W'(1);
            end
         end
         ST_FULL: begin
            if (w_deq) w_count_nxt = c_CNT_W'(NUM_ENTRIES - 1);
         end
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_live   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_live  <= 1'b1;
         if (w_enq) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_deq) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_enq) r_mem[r_wr_ptr] <= w_wr_data;
   end

endmodule
`default_nettype wire

// File: tb/tb_lab1_imul_req_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_lab1_imul_req_queue                                            |
// | Brief   : Directed self-checking bench; follows LAB1_IMUL_REQ_QUEUE_SWAP_EN.|
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_lab1_imul_req_queue;

   logic        clk;
   logic        reset;
   logic [1:0]  count;
   int          n_total;
   int          n_bad;
   logic [31:0] pa [100];
   logic [31:0] pb [100];
   logic [63:0] exp_q [$];
   logic [31:0] prod_q [$];
`ifdef LAB1_IMUL_REQ_QUEUE_SWAP_EN
   logic [31:0] swap_cnt;
`endif

   lab1_imul_req_queue_if #(.NBITS(32)) req_if ();
   lab1_imul_req_queue_if #(.NBITS(32)) out_if ();

   lab1_imul_req_queue #(.NBITS(32), .NUM_ENTRIES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req_if),
      .out      (out_if),
      .count    (count)
`ifdef LAB1_IMUL_REQ_QUEUE_SWAP_EN
      ,
      .swap_cnt (swap_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] canon(input logic [31:0] a, input logic [31:0] b);
`ifdef LAB1_IMUL_REQ_QUEUE_SWAP_EN
      return (b > a) ? {b, a} : {a, b};
`else
      return {a, b};
`endif
   endfunction

   task automatic send1(input logic [31:0] a, input logic [31:0] b);
      req_if.val = 1'b1;
      req_if.msg = {a, b};
      tick();
      req_if.val = 1'b0;
   endtask

   initial begin
      logic [63:0] m;
      logic [31:0] sv_a [3];
      logic [31:0] sv_b [3];
      logic [31:0] sv_cnt [3];
      n_total     = 0;
      n_bad       = 0;
      reset       = 1'b0;
      req_if.val  = 1'b0;
      req_if.msg  = '0;
      out_if.rdy  = 1'b0;

      // reset state
      tick(); tick();
      chk("rst_count", {62'd0, count}, 64'd0);
      chk("rst_out_val", {63'd0, out_if.val}, 64'd0);
      chk("rst_req_rdy", {63'd0, req_if.rdy}, 64'd0);
      reset = 1'b1;
      tick();
      chk("rel_req_rdy", {63'd0, req_if.rdy}, 64'd1);

      // single message
      out_if.rdy = 1'b1;
      req_if.val = 1'b1;
      req_if.msg = {32'd3, 32'd5};
      #1;
      chk("single_no_bypass", {63'd0, out_if.val}, 64'd0);
      tick();
      req_if.val = 1'b0;
      chk("single_out_val", {63'd0, out_if.val}, 64'd1);
`ifdef LAB1_IMUL_REQ_QUEUE_SWAP_EN
      chk("single_msg", out_if.msg, {32'd5, 32'd3});
`else
      chk("single_msg", out_if.msg, {32'd3, 32'd5});
`endif
      tick();
      chk("single_drain", {62'd0, count}, 64'd0);

      // fill and backpressure
      out_if.rdy = 1'b0;
      send1(32'd1, 32'd2);
      send1(32'd3, 32'd4);
      chk("fill_count", {62'd0, count}, 64'd2);
      chk("fill_rdy_low", {63'd0, req_if.rdy}, 64'd0);
      req_if.val = 1'b1;
      req_if.msg = {32'd5, 32'd6};
      tick(); tick();
      chk("fill_held_count", {62'd0, count}, 64'd2);
      chk("fill_head", out_if.msg, canon(32'd1, 32'd2));
      out_if.rdy = 1'b1;
      tick();
      chk("bp_count1", {62'd0, count}, 64'd1);
      chk("bp_msg2", out_if.msg, canon(32'd3, 32'd4));
      tick();
      req_if.val = 1'b0;
      chk("bp_count_stream", {62'd0, count}, 64'd1);
      chk("bp_msg3", out_if.msg, canon(32'd5, 32'd6));
      tick();
      chk("bp_empty", {62'd0, count}, 64'd0);

      // streaming at count==1
      out_if.rdy = 1'b0;
      m = {$urandom(), $urandom()};
      exp_q.push_back(canon(m[63:32], m[31:0]));
      send1(m[63:32], m[31:0]);
      out_if.rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         m = {$urandom(), $urandom()};
         exp_q.push_back(canon(m[63:32], m[31:0]));
         req_if.val = 1'b1;
         req_if.msg = m;
         #1;
         chk("stream_msg", out_if.msg, exp_q.pop_front());
         chk("stream_count", {62'd0, count}, 64'd1);
         tick();
      end
      req_if.val = 1'b0;
      chk("stream_last", out_if.msg, exp_q.pop_front());
      tick();
      chk("stream_empty", {62'd0, count}, 64'd0);

      // reset mid-operation
      out_if.rdy = 1'b0;
      send1(32'h0000_00AA, 32'h0000_00BB);
      send1(32'h0000_00CC, 32'h0000_00DD);
      chk("midrst_full", {62'd0, count}, 64'd2);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_out_val", {63'd0, out_if.val}, 64'd0);
      chk("midrst_req_rdy", {63'd0, req_if.rdy}, 64'd0);
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("midrst_count", {62'd0, count}, 64'd0);
`ifdef LAB1_IMUL_REQ_QUEUE_SWAP_EN
      chk("midrst_swap_cnt", {32'd0, swap_cnt}, 64'd0);
`endif
      out_if.rdy = 1'b1;
      send1(32'd9, 32'd1);
      chk("midrst_new_msg", out_if.msg, {32'd9, 32'd1});
      tick();
      chk("midrst_no_stale", {63'd0, out_if.val}, 64'd0);

      // operand canonicalisation
      sv_a[0] = 32'h0000_0002; sv_b[0] = 32'hFFFF_FFFF; sv_cnt[0] = 32'd1;
      sv_a[1] = 32'd7;         sv_b[1] = 32'd7;         sv_cnt[1] = 32'd1;
      sv_a[2] = 32'd0;         sv_b[2] = 32'h8000_0000; sv_cnt[2] = 32'd2;
      for (int i = 0; i < 3; i++) begin
         send1(sv_a[i], sv_b[i]);
`ifdef LAB1_IMUL_REQ_QUEUE_SWAP_EN
         if (i == 1) chk("swap_msg", out_if.msg, {sv_a[i], sv_b[i]});
         else        chk("swap_msg", out_if.msg, {sv_b[i], sv_a[i]});
         chk("swap_cnt", {32'd0, swap_cnt}, {32'd0, sv_cnt[i]});
`else
         chk("noswap_msg", out_if.msg, {sv_a[i], sv_b[i]});
`endif
         tick();
      end

      // end-to-end through a behavioural multiplier
      pa[0] = 32'd0;         pb[0] = 32'h1234_5678;
      pa[1] = 32'd1;         pb[1] = 32'hFFFF_FFFF;
      pa[2] = 32'hFFFF_FFFF; pb[2] = 32'hFFFF_FFFF;
      pa[3] = 32'h8000_0000; pb[3] = 32'd2;
      pa[4] = 32'hFFFF_FFFF; pb[4] = 32'd0;
      pa[5] = 32'h8000_0000; pb[5] = 32'h8000_0000;
      for (int i = 6; i < 100; i++) begin
         pa[i] = $urandom();
         pb[i] = $urandom();
      end
      begin
         int sent;
         int got;
         int cyc;
         logic [31:0] prod;
         sent = 0;
         got  = 0;
         cyc  = 0;
         while (got < 100 && cyc < 3000) begin
            req_if.val = (sent < 100) && ($urandom_range(0, 3) != 0);
            req_if.msg = {pa[sent % 100], pb[sent % 100]};
            out_if.rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (req_if.val && req_if.rdy) begin
               prod_q.push_back(pa[sent] * pb[sent]);
               sent++;
            end
            if (out_if.val && out_if.rdy) begin
               prod = out_if.msg[63:32] * out_if.msg[31:0];
               if (prod_q.size() == 0) chk("e2e_spurious", 64'd1, 64'd0);
               else                    chk("e2e_prod", {32'd0, prod}, {32'd0, prod_q.pop_front()});
               got++;
            end
            tick();
            cyc++;
         end
         req_if.val = 1'b0;
         chk("e2e_done", 64'(got), 64'd100);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
